mavg_filter: RTL and testbench
==============================

# mavg_filter

Boxcar moving-average filter that sits directly downstream of the decoder stage. It consumes decoded signed 8-bit samples, each qualified by a one-cycle strobe. Each accepted sample produces one registered average of the last DEPTH samples. The result drives the `filtered` output of the top level.

## Interface
- `WIDTH`, default 8: sample and result width, two's-complement signed.
- `DEPTH`, default 8: window length; must be a power of two, 2..64.
- `CLK100MHZ` input 1: sole clock, all state on rising edge.
- `reset_n` input 1: reset, asynchronous assert, active-low; deassertion is synchronised externally.
- `clear` input 1: synchronous flush of window, sum and fill count.
- `sample_in` input WIDTH: signed decoded sample.
- `sample_valid` input 1: one-cycle strobe; `sample_in` is accepted on this cycle.
- `filtered` output WIDTH: signed window average, registered.
- `filtered_valid` output 1: one-cycle strobe; `filtered` is updated on this cycle.
- `primed` output 1: high once DEPTH samples have been accepted since reset or clear.

## Operation
- Window: circular buffer of DEPTH entries, zero after reset or clear. Write pointer `wptr` has log2(DEPTH) bits and wraps from DEPTH-1 to 0 with no special case.
- On an accepted sample:
  - The oldest entry is read at `wptr` and the new sample is written there.
  - Then `sum <= sum + sample_in - oldest` and `wptr <= wptr + 1`.
- `sum` width: WIDTH + log2(DEPTH), signed. No overflow is possible, because the sum is bounded by DEPTH·(−2^(WIDTH−1)) .. DEPTH·(2^(WIDTH−1)−1).
- Result: `filtered <= (sum_next [+ bias]) >>> log2(DEPTH)`, computed on the updated sum. The shift is arithmetic; see Configuration for the bias. The result always fits in WIDTH bits; no saturation logic.
- Fill states:
  - FILL: `fill_cnt` counts accepted samples and `primed`=0. Outputs still issue; the zeros in the window make the output ramp.
  - RUN: entered on the DEPTH-th accepted sample; `primed`=1. Stays in RUN until reset or clear.
- `clear` together with `sample_valid`: clear wins and the sample is dropped. No `filtered_valid` is issued that cycle, and `filtered` holds its value.
- `sample_valid` may be asserted every cycle; there is no backpressure.

## Timing
- Latency is 1 cycle: a sample strobed at edge N gives `filtered` and `filtered_valid` at edge N+1.
- `filtered_valid` is high exactly one cycle per accepted sample.
- Throughput is one sample per clock.
- Reset values:
  - `filtered` = 0, `filtered_valid` = 0, `primed` = 0.
  - Window, sum, `wptr` and `fill_cnt` = 0.
  - State = FILL.
- Reset mid-stream: everything returns to the reset values immediately (asynchronous). The first sample after release starts a new window.
- `clear`: takes effect at the next edge with the same values as reset, except it is synchronous.

## Configuration
- `MAVG_ROUND_EN` defined:
  - bias = 2^(log2(DEPTH)−1) is added before the shift (round half up).
  - Example with DEPTH=8: a sum of −1 gives 0, and a sum of 12 gives 2.
- Not defined:
  - bias = 0, so the result truncates toward −∞.
  - Same example: a sum of −1 gives −1, and a sum of 12 gives 1.

## Structure
- Shared package `mavg_pkg`:
  - Default WIDTH/DEPTH constants.
  - `LOG2_DEPTH` and `SUM_W` derivations.
  - The fill-state enum (FILL, RUN).
- One sub-module, `mavg_ring`: DEPTH×WIDTH circular buffer with write pointer, wrap and zero-on-clear. It exposes the oldest entry combinationally.
- Top of the block holds the sum, fill state machine and output registers.

## Test plan
All cases use DEPTH=8 and WIDTH=8 unless stated.
- **Step ramp:** reset, then 10 strobes of +8 with no rounding → `filtered` = 1,2,3,4,5,6,7,8,8,8; `primed` rises with the 8th output.
- **Rounding:** a single strobe of −1 → `filtered` = −1 without `MAVG_ROUND_EN`, 0 with it.
- **Extremes:** 8 strobes of −128, then 8 of +127 → final outputs −128 and +127, with no wrap or overflow.
- **Back-to-back:** strobes on every cycle for 20 samples → 20 `filtered_valid` pulses, each one cycle after its sample; `wptr` wraps twice and the running values match a reference model.
- **Clear collision:** after priming with +16, assert `clear` together with `sample_valid` on 100 → no valid pulse, `primed`=0; the next sample 16 gives 2.
- **Async reset mid-stream:** drop `reset_n` between edges → outputs are 0 immediately, before the next edge; after release, the first +8 gives 1.

Source files
------------

// File: rtl/mavg_pkg.sv
// Shared constants and fill-state type for the boxcar moving-average filter.
// Default geometry is 8-bit samples over an 8-entry window.
package mavg_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int LOG2_DEPTH = $clog2(DEPTH_DEF);
    localparam int SUM_W      = WIDTH_DEF + LOG2_DEPTH;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/mavg_ring.sv
// DEPTH x WIDTH circular sample window; the entry about to be overwritten
// (the oldest sample) is presented combinationally.
module mavg_ring
    import mavg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] oldest
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;

    // DEPTH is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem  <= '{default: '0};
            r_wptr <= '0;
        end else if (clear) begin
            r_mem  <= '{default: '0};
            r_wptr <= '0;
        end else if (wr_en) begin
            r_mem[r_wptr] <= wr_data;
            r_wptr        <= r_wptr + 1'b1;
        end
    end

    assign oldest = r_mem[r_wptr];

endmodule

// File: rtl/mavg_filter.sv
// Boxcar moving-average filter: running sum over the last DEPTH samples.
// Define MAVG_ROUND_EN to round half up instead of truncating toward -inf.
//
// state   | meaning
// ST_FILL | fewer than DEPTH samples since reset/clear, primed=0
// ST_RUN  | window full, primed=1 until reset or clear
module mavg_filter
    import mavg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    CLK100MHZ,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic signed [WIDTH-1:0] filtered,
    output logic                    filtered_valid,
    output logic                    primed
);

    localparam int LOG2_D = $clog2(DEPTH);
    localparam int SUM_WL = WIDTH + LOG2_D;

    logic signed [WIDTH-1:0]  w_oldest;
    logic signed [SUM_WL-1:0] w_sum_next;
    logic signed [SUM_WL-1:0] w_biased;
    logic signed [WIDTH-1:0]  w_avg;
    logic                     w_accept;

    logic signed [SUM_WL-1:0] r_sum;
    logic [LOG2_D-1:0]        r_fill_cnt;
    fill_state_t              r_state;

    assign w_accept = sample_valid & ~clear;

    mavg_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (CLK100MHZ),
        .rst_n   (reset_n),
        .clear   (clear),
        .wr_en   (w_accept),
        .wr_data (sample_in),
        .oldest  (w_oldest)
    );

    assign w_sum_next = r_sum + SUM_WL'(sample_in) - SUM_WL'(w_oldest);

`ifdef MAVG_ROUND_EN
    localparam logic signed [SUM_WL-1:0] BIAS = SUM_WL'(1) << (LOG2_D - 1);
    assign w_biased = w_sum_next + BIAS;
`else
    assign w_biased = w_sum_next;
`endif

    // Bounded sum keeps the shifted result inside WIDTH bits.
    assign w_avg = WIDTH'(w_biased >>> LOG2_D);

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_sum          <= '0;
            r_fill_cnt     <= '0;
            r_state        <= ST_FILL;
            filtered       <= '0;
            filtered_valid <= 1'b0;
        end else if (clear) begin
            r_sum          <= '0;
            r_fill_cnt     <= '0;
            r_state        <= ST_FILL;
            filtered_valid <= 1'b0;
        end else begin
            filtered_valid <= sample_valid;
            if (sample_valid) begin
                r_sum    <= w_sum_next;
                filtered <= w_avg;
                if (r_state == ST_FILL) begin
                    if (r_fill_cnt == LOG2_D'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                    end
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
            end
        end
    end

    assign primed = (r_state == ST_RUN);

endmodule

// File: tb/tb_mavg_filter.sv
// Self-checking bench for mavg_filter (WIDTH=8, DEPTH=8) against a
// queue-based window-average reference model.
module tb_mavg_filter;

    logic              CLK100MHZ = 1'b0;
    logic              reset_n;
    logic              clear;
    logic signed [7:0] sample_in;
    logic              sample_valid;
    logic signed [7:0] filtered;
    logic              filtered_valid;
    logic              primed;

    int n_tests = 0;
    int n_fail  = 0;

    int hist[$];
    int acc_cnt   = 0;
    int exp_filt  = 0;
    bit exp_valid = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    mavg_filter dut (
        .CLK100MHZ      (CLK100MHZ),
        .reset_n        (reset_n),
        .clear          (clear),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .filtered       (filtered),
        .filtered_valid (filtered_valid),
        .primed         (primed)
    );

    // Mean of the last 8 accepted samples (missing ones count as zero), floored.
    function automatic int model_avg();
        int s = 0;
        foreach (hist[i]) s += hist[i];
`ifdef MAVG_ROUND_EN
        s += 4;
`endif
        if (s >= 0) return s / 8;
        else return -((-s + 7) / 8);
    endfunction

    function automatic bit exp_primed();
        return acc_cnt >= 8;
    endfunction

    task automatic model_reset();
        hist.delete();
        acc_cnt   = 0;
        exp_filt  = 0;
        exp_valid = 0;
    endtask

    task automatic step(input bit v, input int d, input bit c);
        sample_valid = v;
        sample_in    = 8'(d);
        clear        = c;
        @(posedge CLK100MHZ);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b0;
        if (c) begin
            hist.delete();
            acc_cnt   = 0;
            exp_valid = 0;
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
            acc_cnt++;
            exp_filt  = model_avg();
            exp_valid = 1;
        end else begin
            exp_valid = 0;
        end
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (2) @(posedge CLK100MHZ);
        #1;
        n_tests++;
        if (filtered !== 8'sd0) begin
            n_fail++; $display("FAIL reset_filtered got %0d want 0", filtered);
        end
        n_tests++;
        if (filtered_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %0b want 0", filtered_valid);
        end
        n_tests++;
        if (primed !== 1'b0) begin
            n_fail++; $display("FAIL reset_primed got %0b want 0", primed);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_step_ramp();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 8, 0);
            n_tests++;
            if (filtered !== 8'(((i + 1) < 8) ? (i + 1) : 8)) begin
                n_fail++; $display("FAIL ramp[%0d] filtered got %0d want %0d", i, filtered, ((i + 1) < 8) ? (i + 1) : 8);
            end
            n_tests++;
            if (primed !== (i >= 7)) begin
                n_fail++; $display("FAIL ramp_primed[%0d] got %0b want %0b", i, primed, (i >= 7));
            end
            n_tests++;
            if (filtered_valid !== 1'b1) begin
                n_fail++; $display("FAIL ramp_valid[%0d] got %0b want 1", i, filtered_valid);
            end
        end
    endtask

    task automatic test_rounding();
        int want;
`ifdef MAVG_ROUND_EN
        want = 0;
`else
        want = -1;
`endif
        do_reset();
        step(1, -1, 0);
        n_tests++;
        if (filtered !== 8'(want)) begin
            n_fail++; $display("FAIL round_neg1 got %0d want %0d", filtered, want);
        end
        for (int i = 0; i < 2; i++) step(1, 6, 0);
        n_tests++;
        if (filtered !== 8'(exp_filt)) begin
            n_fail++; $display("FAIL round_sum11 got %0d want %0d", filtered, exp_filt);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, (i < 8) ? -128 : 127, 0);
            n_tests++;
            if (filtered !== 8'(exp_filt)) begin
                n_fail++; $display("FAIL extreme[%0d] got %0d want %0d", i, filtered, exp_filt);
            end
            if (i == 7) begin
                n_tests++;
                if (filtered !== -8'sd128) begin
                    n_fail++; $display("FAIL extreme_min got %0d want -128", filtered);
                end
            end
        end
        n_tests++;
        if (filtered !== 8'sd127) begin
            n_fail++; $display("FAIL extreme_max got %0d want 127", filtered);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, $signed(8'($urandom)), 0);
            if (filtered_valid === 1'b1) pulses++;
            n_tests++;
            if (filtered !== 8'(exp_filt)) begin
                n_fail++; $display("FAIL b2b[%0d] filtered got %0d want %0d", i, filtered, exp_filt);
            end
            n_tests++;
            if (primed !== exp_primed()) begin
                n_fail++; $display("FAIL b2b_primed[%0d] got %0b want %0b", i, primed, exp_primed());
            end
        end
        step(0, 0, 0);
        if (filtered_valid === 1'b1) pulses++;
        n_tests++;
        if (pulses !== 20) begin
            n_fail++; $display("FAIL b2b_pulses got %0d want 20", pulses);
        end
    endtask

    task automatic test_clear_collision();
        int held;
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 16, 0);
        held = exp_filt;
        step(1, 100, 1);
        n_tests++;
        if (filtered_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_valid got %0b want 0", filtered_valid);
        end
        n_tests++;
        if (primed !== 1'b0) begin
            n_fail++; $display("FAIL clr_primed got %0b want 0", primed);
        end
        n_tests++;
        if (filtered !== 8'(held)) begin
            n_fail++; $display("FAIL clr_hold got %0d want %0d", filtered, held);
        end
        step(1, 16, 0);
        n_tests++;
        if (filtered !== 8'sd2) begin
            n_fail++; $display("FAIL clr_next got %0d want 2", filtered);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 40, 0);
        n_tests++;
        if (filtered !== 8'(exp_filt) || primed !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre got %0d/%0b want %0d/1", filtered, primed, exp_filt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (filtered !== 8'sd0 || filtered_valid !== 1'b0 || primed !== 1'b0) begin
            n_fail++; $display("FAIL arst_immediate got %0d/%0b/%0b want 0/0/0", filtered, filtered_valid, primed);
        end
        @(posedge CLK100MHZ);
        #1;
        reset_n = 1'b1;
        model_reset();
        step(1, 8, 0);
        n_tests++;
        if (filtered !== 8'sd1 || filtered_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_after got %0d/%0b want 1/1", filtered, filtered_valid);
        end
    endtask

    task automatic test_random();
        bit v;
        bit c;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            v = bit'($urandom_range(0, 3) != 0);
            c = bit'($urandom_range(0, 19) == 0);
            step(v, $signed(8'($urandom)), c);
            n_tests++;
            if (filtered !== 8'(exp_filt) || filtered_valid !== exp_valid || primed !== exp_primed()) begin
                n_fail++;
                $display("FAIL rand[%0d] got %0d/%0b/%0b want %0d/%0b/%0b", i, filtered, filtered_valid, primed, exp_filt, exp_valid, exp_primed());
            end
        end
    endtask

    initial begin
        test_reset();
        test_step_ramp();
        test_rounding();
        test_extremes();
        test_back_to_back();
        test_clear_collision();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
